mips_cpu_lsu: RTL
=================

// Module: mips_cpu_lsu
// PURPOSE
//  Multi-cycle load/store unit for the MIPS CPU, placed between the EXEC stage and the data memory bus.
//  Computes the effective address and steers byte lanes for LB/LBU/LH/LHU/LW/LWL/LWR/SB/SH/SW.
//  Handles a waitrequest handshake, misalignment and bus-timeout errors.
//  The CPU stalls from request until a one-cycle response pulse.
// PARAMETERS
//  TIMEOUT_CYCLES  0  cycles of waitrequest tolerated before resp_err; 0 = wait forever
//  SUPPORT_LWLR    1  1 = implement LWL/LWR; 0 = LWL/LWR return resp_err without a bus access
//  ALIGN_CHECK     1  1 = misaligned LH/LHU/SH/LW/SW return resp_err; 0 = low address bits ignored
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, synchronous, active-high
//  req_valid       in   1   CPU request strobe
//  req_ready       out  1   high only in IDLE
//  req_op          in   4   lsu_op_t
//  req_base        in   32  rs value
//  req_offset      in   16  signed immediate
//  req_wdata       in   32  rt value (stores)
//  req_rt_old      in   32  current rt value (LWL/LWR merge)
//  resp_valid      out  1   one-cycle completion pulse
//  resp_rdata      out  32  load result, extended or merged; 0 for stores
//  resp_err        out  1   valid with resp_valid: misaligned, unsupported or timeout
//  avm_address     out  32  word-aligned byte address ({ea[31:2],2'b00})
//  avm_read        out  1   bus read
//  avm_write       out  1   bus write
//  avm_byteenable  out  4   active lanes
//  avm_writedata   out  32  lane-steered store data
//  avm_waitrequest in   1   slave stall
//  avm_readdata    in   32  valid the cycle after a read is accepted
// BEHAVIOUR
//  Reset:
//   - state IDLE; req_ready=1; all other outputs 0; timeout counter 0.
//   - rst mid-transaction abandons it at that edge; no response is produced.
//  Effective address: ea = req_base + sext(req_offset), mod 2^32. Latched with op and data on accept.
//  Little-endian lanes: byte k = ea[1:0] occupies bits [8k+7:8k].
//  FSM IDLE -> BUS -> [RDATA] -> RESP -> IDLE
//   - IDLE: accept when req_valid. If error, go to RESP with err=1 and no bus strobe; else go to BUS.
//   - BUS:
//     - Strobes and address are registered and held stable while avm_waitrequest=1.
//     - On the cycle waitrequest=0: write -> RESP; read -> RDATA.
//     - Timeout: counter++ each waitrequest=1 cycle. If TIMEOUT_CYCLES>0 and count==TIMEOUT_CYCLES:
//       drop strobes, go to RESP with err=1.
//   - RDATA: capture avm_readdata and form the result; go to RESP.
//   - RESP: resp_valid=1 for exactly one cycle; go to IDLE.
//  Latency with zero wait states:
//   - store: accept T, strobe T+1, resp T+2.
//   - load: resp T+3.
//   - error: resp T+1.
//  Byteenable and write data:
//   - SB: be = 1<<k; byte replicated on all lanes.
//   - SH: be = 0011 or 1100; halfword replicated.
//   - SW: be = 1111.
//   - Loads read all 4 lanes (be = 1111).
//  Extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
//  LWL (k): rdata = (mem << 8*(3-k)) | (rt_old & ((1<<8*(3-k))-1)).
//  LWR (k): rdata = (mem >> 8k) | (rt_old & ~(32'hFFFFFFFF >> 8k)).
//  req_valid while not IDLE is ignored (req_ready=0).
//  avm_read and avm_write are never high together.
// STRUCTURE
//  mips_cpu_pkg: lsu_op_t (LSU_LB, LSU_LBU, LSU_LH, LSU_LHU, LSU_LW, LSU_LWL, LSU_LWR, LSU_SB, LSU_SH, LSU_SW) and lsu_state_t.
//  Sub-module mips_cpu_lsu_align (combinational):
//   - store: op, k, wdata -> be, writedata.
//   - load:  op, k, readdata, rt_old -> rdata.
//   - Reused by the future bus-interface CPU.
// TESTING
//  1. base=0x1000, off=-4, LW, mem[0xFFC]=0xDEADBEEF, no wait -> avm_address 0xFFC, be 1111;
//     resp_rdata 0xDEADBEEF at T+3, err 0.
//  2. LB at 0x1003, word 0x80FF7F01 -> 0xFFFFFF80. LBU -> 0x00000080. LHU at 0x1002 -> 0x000080FF.
//  3. SB 0x2001, wdata 0x000000AB -> be 0010, writedata 0xABABABAB. SH 0x2002 -> be 1100.
//  4. LH at 0x1001 with ALIGN_CHECK=1 -> no avm_read ever; resp_valid+err at T+1.
//  5. LWL k=1, mem 0x44332211, rt_old 0xAABBCCDD -> 0x2211CCDD. LWR k=1 -> 0xAA443322.
//  6. waitrequest held 3 cycles -> strobes and address stable, resp at T+6.
//     TIMEOUT_CYCLES=2 -> err at 2nd stall. rst during BUS -> strobes 0 next cycle, no resp.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared types for the MIPS CPU load/store unit
package mips_cpu_pkg;

    typedef enum logic [3:0] {
        LSU_LB, LSU_LBU, LSU_LH, LSU_LHU, LSU_LW,
        LSU_LWL, LSU_LWR, LSU_SB, LSU_SH, LSU_SW
    } lsu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE, ST_BUS, ST_RDATA, ST_RESP
    } lsu_state_t;

    function automatic logic is_store(input logic [3:0] op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// rtl/mips_cpu_lsu_align.sv - byte-lane steering for stores and extension/merge for loads
module mips_cpu_lsu_align
    import mips_cpu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [1:0]  k,
    input  logic [31:0] wdata,
    input  logic [31:0] readdata,
    input  logic [31:0] rt_old,
    output logic [3:0]  be,
    output logic [31:0] writedata,
    output logic [31:0] rdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [4:0]  sh_l;
    logic [4:0]  sh_r;

    always_comb begin
        byte_sel  = readdata[{k, 3'b000} +: 8];
        half_sel  = k[1] ? readdata[31:16] : readdata[15:0];
        // LWL shifts by 8*(3-k); for a 2-bit k, 3-k is simply ~k
        sh_l      = {~k, 3'b000};
        sh_r      = {k, 3'b000};
        be        = 4'b1111;
        writedata = '0;
        rdata     = '0;
        case (op)
            LSU_LB:  rdata = {{24{byte_sel[7]}}, byte_sel};
            LSU_LBU: rdata = {24'b0, byte_sel};
            LSU_LH:  rdata = {{16{half_sel[15]}}, half_sel};
            LSU_LHU: rdata = {16'b0, half_sel};
            LSU_LW:  rdata = readdata;
            LSU_LWL: rdata = (readdata << sh_l) | (rt_old & ((32'h1 << sh_l) - 32'h1));
            LSU_LWR: rdata = (readdata >> sh_r) | (rt_old & ~(32'hFFFF_FFFF >> sh_r));
            LSU_SB: begin
                be        = 4'b0001 << k;
                writedata = {4{wdata[7:0]}};
            end
            LSU_SH: begin
                be        = k[1] ? 4'b1100 : 4'b0011;
                writedata = {2{wdata[15:0]}};
            end
            LSU_SW:  writedata = wdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_cpu_lsu.sv
// rtl/mips_cpu_lsu.sv - multi-cycle load/store unit between EXEC and the data memory bus
module mips_cpu_lsu
    import mips_cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0,
    parameter int SUPPORT_LWLR   = 1,
    parameter int ALIGN_CHECK    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_base,
    input  logic [15:0] req_offset,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_rt_old,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [3:0]  avm_byteenable,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata
);

    lsu_state_t  state, state_next;
    logic [3:0]  op_q;
    logic [1:0]  k_q;
    logic [31:0] rt_old_q;
    logic [31:0] cnt;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] ea;
    logic        misalign, unsupported, req_err, timeout_hit;
    logic [3:0]  op_sel;
    logic [1:0]  k_sel;
    logic [3:0]  be;
    logic [31:0] writedata, rdata;

    assign ea          = req_base + {{16{req_offset[15]}}, req_offset};
    assign unsupported = (SUPPORT_LWLR == 0) && ((req_op == LSU_LWL) || (req_op == LSU_LWR));
    assign req_err     = misalign | unsupported;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && avm_waitrequest
                         && ((cnt + 32'd1) == 32'(TIMEOUT_CYCLES));

    always_comb begin
        misalign = 1'b0;
        if (ALIGN_CHECK != 0) begin
            case (req_op)
                LSU_LH, LSU_LHU, LSU_SH: misalign = ea[0];
                LSU_LW, LSU_SW:          misalign = |ea[1:0];
                default:                 ;
            endcase
        end
    end

    // One aligner serves both directions: request fields while idle, latched fields afterwards
    assign op_sel = (state == ST_IDLE) ? req_op : op_q;
    assign k_sel  = (state == ST_IDLE) ? ea[1:0] : k_q;

    mips_cpu_lsu_align u_align (
        .op        (op_sel),
        .k         (k_sel),
        .wdata     (req_wdata),
        .readdata  (avm_readdata),
        .rt_old    (rt_old_q),
        .be        (be),
        .writedata (writedata),
        .rdata     (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (req_valid) state_next = req_err ? ST_RESP : ST_BUS;
            ST_BUS: begin
                if (!avm_waitrequest) state_next = is_store(op_q) ? ST_RESP : ST_RDATA;
                else if (timeout_hit) state_next = ST_RESP;
            end
            ST_RDATA: state_next = ST_RESP;
            ST_RESP:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    assign req_ready  = (state == ST_IDLE);
    assign resp_valid = (state == ST_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q           <= '0;
            k_q            <= '0;
            rt_old_q       <= '0;
            cnt            <= '0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
            avm_address    <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_byteenable <= '0;
            avm_writedata  <= '0;
        end else begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    op_q     <= req_op;
                    k_q      <= ea[1:0];
                    rt_old_q <= req_rt_old;
                    cnt      <= '0;
                    rdata_q  <= '0;
                    err_q    <= req_err;
                    if (!req_err) begin
                        avm_address    <= {ea[31:2], 2'b00};
                        avm_byteenable <= be;
                        avm_writedata  <= writedata;
                        avm_read       <= !is_store(req_op);
                        avm_write      <= is_store(req_op);
                    end
                end
                ST_BUS: begin
                    if (avm_waitrequest) cnt <= cnt + 32'd1;
                    if (!avm_waitrequest || timeout_hit) begin
                        avm_read  <= 1'b0;
                        avm_write <= 1'b0;
                        err_q     <= timeout_hit;
                    end
                end
                ST_RDATA: rdata_q <= rdata;
                default:  ;
            endcase
        end
    end

endmodule
